// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Wide enough for any practical STARVE_LIMIT (up to 255).
    localparam int STARVE_W = 8;

    function automatic logic [STARVE_W-1:0] starve_inc(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] lim
    );
        logic [STARVE_W-1:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Free-running grant and stall event counters for the memory port arbiter.
module mem_arb_perf_cnt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_gnt,
    input  logic        d_gnt,
    input  logic        if_stall,
    input  logic        d_stall,
    output logic [31:0] cnt_if_gnt,
    output logic [31:0] cnt_d_gnt,
    output logic [31:0] cnt_if_stall,
    output logic [31:0] cnt_d_stall
);

    logic [31:0] if_gnt_r;
    logic [31:0] d_gnt_r;
    logic [31:0] if_stall_r;
    logic [31:0] d_stall_r;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            if_gnt_r   <= 32'd0;
            d_gnt_r    <= 32'd0;
            if_stall_r <= 32'd0;
            d_stall_r  <= 32'd0;
        end else begin
            if_gnt_r   <= if_gnt   ? if_gnt_r   + 32'd1 : if_gnt_r;
            d_gnt_r    <= d_gnt    ? d_gnt_r    + 32'd1 : d_gnt_r;
            if_stall_r <= if_stall ? if_stall_r + 32'd1 : if_stall_r;
            d_stall_r  <= d_stall  ? d_stall_r  + 32'd1 : d_stall_r;
        end
    end

    assign cnt_if_gnt   = if_gnt_r;
    assign cnt_d_gnt    = d_gnt_r;
    assign cnt_if_stall = if_stall_r;
    assign cnt_d_stall  = d_stall_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port memory bus,
// one transaction in flight. Define MEM_ARB_PERF_CNT_EN to add performance counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_done,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_stall,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_done,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_stall,
    output logic              o_mem_valid,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       o_cnt_if_gnt,
    output logic [31:0]       o_cnt_d_gnt,
    output logic [31:0]       o_cnt_if_stall,
    output logic [31:0]       o_cnt_d_stall
`endif
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_r;
    arb_state_t          state_s;
    arb_owner_t          owner_r;
    logic                drop_r;
    logic [STARVE_W-1:0] starve_cnt_r;
    logic                mem_valid_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                if_done_r;
    logic                d_done_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;

    logic                if_req_eff_s;
    logic                d_win_s;
    logic                if_win_s;
    logic                if_flush_live_s;
    logic                drop_s;

    // Arbitration and flush qualification; a flushed fetch is not a candidate.
    always_comb begin
        if_req_eff_s    = i_if_req & ~i_if_flush;
        d_win_s         = i_d_req & ~(if_req_eff_s & (starve_cnt_r == STARVE_MAX));
        if_win_s        = if_req_eff_s & ~d_win_s;
        if_flush_live_s = i_if_flush & (owner_r == OWN_IF) &
                          ((state_r == ISSUE) | (state_r == WAIT));
        drop_s          = drop_r | if_flush_live_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (d_win_s | if_win_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                // Once the bus accepts, the read response must still be drained.
                if (i_mem_ready) begin
                    state_s = mem_we_r ? DONE : WAIT;
                end else if (if_flush_live_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ISSUE;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, bus registers, starvation counter, response capture and done pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= IDLE;
            owner_r      <= OWN_IF;
            drop_r       <= 1'b0;
            starve_cnt_r <= {STARVE_W{1'b0}};
            mem_valid_r  <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            if_done_r    <= 1'b0;
            d_done_r     <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            mem_valid_r <= (state_s == ISSUE);
            if_done_r   <= 1'b0;
            d_done_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (d_win_s) begin
                        owner_r      <= OWN_D;
                        drop_r       <= 1'b0;
                        mem_we_r     <= i_d_we;
                        mem_addr_r   <= i_d_addr;
                        mem_wdata_r  <= i_d_wdata;
                        starve_cnt_r <= if_req_eff_s ? starve_inc(starve_cnt_r, STARVE_MAX)
                                                     : starve_cnt_r;
                    end else if (if_win_s) begin
                        owner_r      <= OWN_IF;
                        drop_r       <= 1'b0;
                        mem_we_r     <= 1'b0;
                        mem_addr_r   <= i_if_addr;
                        mem_wdata_r  <= {DATA_W{1'b0}};
                        starve_cnt_r <= {STARVE_W{1'b0}};
                    end else begin
                        starve_cnt_r <= starve_cnt_r;
                    end
                end
                ISSUE: begin
                    if (i_mem_ready) begin
                        drop_r   <= drop_s;
                        d_done_r <= mem_we_r;
                    end else begin
                        drop_r   <= drop_r;
                    end
                end
                WAIT: begin
                    drop_r <= drop_s;
                    if (i_mem_rvalid) begin
                        if (owner_r == OWN_D) begin
                            d_rdata_r <= i_mem_rdata;
                            d_done_r  <= 1'b1;
                        end else if (!drop_s) begin
                            if_rdata_r <= i_mem_rdata;
                            if_done_r  <= 1'b1;
                        end else begin
                            if_done_r  <= 1'b0;
                        end
                    end else begin
                        d_done_r <= 1'b0;
                    end
                end
                DONE: begin
                    drop_r <= 1'b0;
                end
                default: begin
                    drop_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_done   = if_done_r;
    assign o_if_rdata  = if_rdata_r;
    assign o_d_done    = d_done_r;
    assign o_d_rdata   = d_rdata_r;
    assign o_mem_valid = mem_valid_r;
    assign o_mem_we    = mem_we_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_mem_wdata = mem_wdata_r;
    // A dropped fetch never pulses done, so its stall persists through the drain.
    assign o_if_stall  = i_if_req & ~if_done_r;
    assign o_d_stall   = i_d_req & ~d_done_r;

`ifdef MEM_ARB_PERF_CNT_EN
    logic if_gnt_s;
    logic d_gnt_s;

    assign if_gnt_s = (state_r == IDLE) & if_win_s;
    assign d_gnt_s  = (state_r == IDLE) & d_win_s;

    mem_arb_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rstn         (rstn),
        .if_gnt       (if_gnt_s),
        .d_gnt        (d_gnt_s),
        .if_stall     (o_if_stall),
        .d_stall      (o_d_stall),
        .cnt_if_gnt   (o_cnt_if_gnt),
        .cnt_d_gnt    (o_cnt_d_gnt),
        .cnt_if_stall (o_cnt_if_stall),
        .cnt_d_stall  (o_cnt_d_stall)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small bus responder.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_if_req, i_if_flush, i_d_req, i_d_we;
    logic [31:0] i_if_addr, i_d_addr, i_d_wdata;
    logic        o_if_done, o_if_stall, o_d_done, o_d_stall;
    logic [31:0] o_if_rdata, o_d_rdata;
    logic        o_mem_valid, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        i_mem_ready = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] o_cnt_if_gnt, o_cnt_d_gnt, o_cnt_if_stall, o_cnt_d_stall;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rstn(rstn),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_done(o_if_done), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_done(o_d_done), .o_d_rdata(o_d_rdata), .o_d_stall(o_d_stall),
        .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        , .o_cnt_if_gnt(o_cnt_if_gnt), .o_cnt_d_gnt(o_cnt_d_gnt),
        .o_cnt_if_stall(o_cnt_if_stall), .o_cnt_d_stall(o_cnt_d_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: a few fixed words, everything else derived from the address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        else if (a == 32'h200) return 32'hCAFE0200;
        else return a ^ 32'h5A5A5A5A;
    endfunction

    int          ready_delay = 0;
    int          rv_delay    = 0;
    int          waitc       = 0;
    bit          rd_pend     = 1'b0;
    int          rv_cnt      = 0;
    logic [31:0] rd_addr     = 32'h0;

    // Bus responder: ready after ready_delay cycles of valid, rvalid rv_delay cycles after accept.
    always @(negedge clk) begin
        i_mem_rvalid = 1'b0;
        if (rd_pend) begin
            if (rv_cnt == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = mem_data(rd_addr);
                rd_pend      = 1'b0;
            end else begin
                rv_cnt = rv_cnt - 1;
            end
        end
        i_mem_ready = 1'b0;
        if (o_mem_valid) begin
            if (waitc >= ready_delay) begin
                i_mem_ready = 1'b1;
                waitc = 0;
                if (!o_mem_we) begin
                    rd_pend = 1'b1;
                    rv_cnt  = rv_delay;
                    rd_addr = o_mem_addr;
                end
            end else begin
                waitc = waitc + 1;
            end
        end else begin
            waitc = 0;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    bit cnt_en = 1'b0;
    int sum_if_stall = 0;
    int sum_d_stall  = 0;
    always @(negedge clk) begin
        if (cnt_en) begin
            sum_if_stall += int'(o_if_stall);
            sum_d_stall  += int'(o_d_stall);
        end
    end
`endif

    // One transaction on the chosen port from an idle arbiter, then one idle cycle.
    task automatic run_txn(input bit is_if, input logic [31:0] addr);
        bit got;
        got = 1'b0;
        if (is_if) begin i_if_req = 1'b1; i_if_addr = addr; end
        else begin i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = addr; end
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = is_if ? o_if_done : o_d_done;
        end
        chk_eq(is_if ? "txn_if_done" : "txn_d_done", {31'd0, got}, 32'd1);
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        string exp_seq;
        int    nwin;
        int    ndone;
        logic [31:0] rd;

        rstn = 1'b0; i_if_req = 1'b0; i_if_flush = 1'b0; i_d_req = 1'b0; i_d_we = 1'b0;
        i_if_addr = 32'h0; i_d_addr = 32'h0; i_d_wdata = 32'h0;
        step(); step(); step();
        chk_eq("rst_valid", {31'd0, o_mem_valid}, 32'd0);
        chk_eq("rst_addr", o_mem_addr, 32'h0);
        chk_eq("rst_dones", {30'd0, o_if_done, o_d_done}, 32'd0);
        chk_eq("rst_rdata", o_d_rdata | o_if_rdata, 32'h0);
        rstn = 1'b1;
        step();

        // Lone load: valid @1, rvalid @2, done @3.
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h100;
        step();
        chk_eq("ld_valid_c1", {31'd0, o_mem_valid}, 32'd1);
        chk_eq("ld_addr_c1", o_mem_addr, 32'h100);
        chk_eq("ld_dstall_c1", {31'd0, o_d_stall}, 32'd1);
        step();
        chk_eq("ld_valid_c2", {31'd0, o_mem_valid}, 32'd0);
        chk_eq("ld_done_c2", {31'd0, o_d_done}, 32'd0);
        step();
        chk_eq("ld_done_c3", {31'd0, o_d_done}, 32'd1);
        chk_eq("ld_rdata", o_d_rdata, 32'hDEADBEEF);
        chk_eq("ld_ifdone", {31'd0, o_if_done}, 32'd0);
        chk_eq("ld_dstall_c3", {31'd0, o_d_stall}, 32'd0);
        chk_eq("ld_ifstall", {31'd0, o_if_stall}, 32'd0);
        i_d_req = 1'b0;
        step();
        chk_eq("ld_done_c4", {31'd0, o_d_done}, 32'd0);

        // Both ports requesting continuously: starvation limit forces every fifth grant to fetch.
        exp_seq = "DDDDIDDDDI";
        nwin = 0;
        i_if_req = 1'b1; i_if_addr = 32'h1000; i_d_req = 1'b1; i_d_addr = 32'h2000;
        for (int cyc = 0; cyc < 200 && nwin < 10; cyc++) begin
            step();
            if (o_if_done || o_d_done) begin
                chk_eq("one_done", {31'd0, o_if_done & o_d_done}, 32'd0);
                chk_eq($sformatf("win%0d_is_d", nwin), {31'd0, o_d_done},
                       (exp_seq[nwin] == "D") ? 32'd1 : 32'd0);
                nwin++;
                if (nwin == 10) begin i_if_req = 1'b0; i_d_req = 1'b0; end
            end
        end
        chk_eq("win_count", nwin, 32'd10);
        step(); step();

        // Store with ready held low for three cycles; a stray flush must not disturb it.
        ready_delay = 3;
        i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h40; i_d_wdata = 32'h12345678;
        for (int c = 1; c <= 4; c++) begin
            step();
            i_if_flush = (c == 2);
            chk_eq($sformatf("st_valid_c%0d", c), {31'd0, o_mem_valid}, 32'd1);
            chk_eq($sformatf("st_we_c%0d", c), {31'd0, o_mem_we}, 32'd1);
            chk_eq($sformatf("st_addr_c%0d", c), o_mem_addr, 32'h40);
            chk_eq($sformatf("st_wdata_c%0d", c), o_mem_wdata, 32'h12345678);
            chk_eq($sformatf("st_done_c%0d", c), {31'd0, o_d_done}, 32'd0);
        end
        i_if_flush = 1'b0;
        step();
        chk_eq("st_done_c5", {31'd0, o_d_done}, 32'd1);
        chk_eq("st_valid_c5", {31'd0, o_mem_valid}, 32'd0);
        i_d_req = 1'b0; i_d_we = 1'b0;
        step();
        chk_eq("st_done_c6", {31'd0, o_d_done}, 32'd0);

        // Flush of a fetch still waiting in ISSUE: dropped before acceptance.
        ready_delay = 2;
        i_if_req = 1'b1; i_if_addr = 32'h700;
        step();
        chk_eq("fi_valid_c1", {31'd0, o_mem_valid}, 32'd1);
        chk_eq("fi_addr_c1", o_mem_addr, 32'h700);
        i_if_flush = 1'b1; i_if_req = 1'b0;
        step();
        i_if_flush = 1'b0;
        chk_eq("fi_valid_c2", {31'd0, o_mem_valid}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            ndone += int'(o_if_done) + int'(o_mem_valid);
        end
        chk_eq("fi_quiet", ndone, 32'd0);
        ready_delay = 0;

        // Flush of an accepted fetch in WAIT: response drained, done suppressed, redirect served.
        rv_delay = 2;
        i_if_req = 1'b1; i_if_addr = 32'h300;
        step();
        step();
        chk_eq("fw_wait_valid", {31'd0, o_mem_valid}, 32'd0);
        i_if_flush = 1'b1; i_if_addr = 32'h200;
        step();
        i_if_flush = 1'b0; rv_delay = 0;
        ndone = 0; rd = 32'h0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (k == 1) begin
                chk_eq("fw_drop_done", {31'd0, o_if_done}, 32'd0);
                chk_eq("fw_drop_stall", {31'd0, o_if_stall}, 32'd1);
            end
            if (o_if_done) begin
                ndone++;
                rd = o_if_rdata;
                i_if_req = 1'b0;
            end
        end
        chk_eq("fw_done_count", ndone, 32'd1);
        chk_eq("fw_rdata", rd, 32'hCAFE0200);

        // Reset while waiting on a read; the late response arrives after release.
        rv_delay = 3;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h500;
        step();
        step();
        chk_eq("rw_wait_valid", {31'd0, o_mem_valid}, 32'd0);
        rstn = 1'b0; i_d_req = 1'b0;
        step();
        chk_eq("rw_rst_valid", {31'd0, o_mem_valid}, 32'd0);
        chk_eq("rw_rst_dones", {30'd0, o_if_done, o_d_done}, 32'd0);
        chk_eq("rw_rst_rdata", o_d_rdata | o_if_rdata, 32'h0);
        chk_eq("rw_rst_addr", o_mem_addr, 32'h0);
        rstn = 1'b1;
        ndone = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            ndone += int'(o_d_done) + int'(o_if_done) + int'(o_mem_valid);
        end
        chk_eq("rw_stray_ignored", ndone, 32'd0);
        chk_eq("rw_rdata_kept0", o_d_rdata, 32'h0);
        rv_delay = 0;

        // Arbiter recovers: a plain load still works after the stray response.
        run_txn(1'b0, 32'h100);

`ifdef MEM_ARB_PERF_CNT_EN
        rstn = 1'b0;
        step();
        rstn = 1'b1; cnt_en = 1'b1;
        chk_eq("pc_if_gnt_rst", o_cnt_if_gnt, 32'd0);
        chk_eq("pc_d_stall_rst", o_cnt_d_stall, 32'd0);
        run_txn(1'b1, 32'h200); run_txn(1'b0, 32'h100);
        run_txn(1'b1, 32'h204); run_txn(1'b0, 32'h104);
        run_txn(1'b1, 32'h208); run_txn(1'b0, 32'h108);
        run_txn(1'b1, 32'h20C); run_txn(1'b1, 32'h210);
        step();
        cnt_en = 1'b0;
        chk_eq("pc_if_gnt", o_cnt_if_gnt, 32'd5);
        chk_eq("pc_d_gnt", o_cnt_d_gnt, 32'd3);
        chk_eq("pc_if_stall", o_cnt_if_stall, 32'd15);
        chk_eq("pc_d_stall", o_cnt_d_stall, 32'd9);
        chk_eq("pc_if_stall_obs", o_cnt_if_stall, sum_if_stall);
        chk_eq("pc_d_stall_obs", o_cnt_d_stall, sum_d_stall);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
